// File: rtl/unified_mem_responder.sv
// unified_mem_responder
//   Responder for the core's unified single-ported memory. Arbitrates between
//   instruction fetch and load/store data, performs RISC-V byte/half/word
//   accesses with sign/zero extension, and splits halfword-aligned fetches
//   that straddle a word boundary into two array reads.
//
// Ports
//   clk, rst        clock; asynchronous active-low reset
//   if_req/if_addr  fetch request; if_gnt accept (comb); if_rvalid/if_rdata response
//   d_req/d_we/d_func/d_addr/d_wdata  data request; d_gnt accept (comb)
//   d_rvalid/d_rdata/d_err            data response (d_err qualified by d_rvalid)
//
// Configuration
//   MISALIGN_TRAP_EN  defined: misaligned/illegal data accesses are not
//                     performed and answer with d_err=1, d_rdata=0.
//                     undefined: d_err=0, low address bits ignored for
//                     half/word, codes 011/110/111 act as word.
module unified_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_func,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  typedef enum logic {IDLE, FETCH_HI} state_e;

  // decoded data access
  typedef struct packed {
    logic       bad;   // misaligned/illegal, trapped
    logic [1:0] size;  // 0 byte, 1 half, 2 word
    logic [1:0] off;   // byte lane of the access
    logic       sext;
  } d_dec_t;

  logic [31:0] mem [DEPTH_WORDS];

  state_e          state_q, state_d;
  logic            prev_d_q, prev_d_d;
  logic [15:0]     hold_q, hold_d;
  logic [IDX_W-1:0] hi_idx_q, hi_idx_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic [31:0]     if_rdata_q, if_rdata_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [31:0]     d_rdata_q, d_rdata_d;
  logic            d_err_q, d_err_d;

  logic [IDX_W-1:0] if_idx, d_idx, rd_idx;
  logic [31:0]      rd_word, shifted, ld_data, mem_wdata;
  logic [3:0]       mem_be;
  logic             mem_we;
  d_dec_t           dec;

  assign if_idx = if_addr[IDX_W+1:2];
  assign d_idx  = d_addr[IDX_W+1:2];

  logic unused_bits;
  assign unused_bits = ^{if_addr[0], if_addr[ADDR_W-1:IDX_W+2], d_addr[ADDR_W-1:IDX_W+2]};

  // Arbitration and the single read-port address. Grants are forced low
  // while reset is asserted so they drop immediately.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    rd_idx = d_idx;
    if (state_q == FETCH_HI) begin
      rd_idx = hi_idx_q;
    end else if (rst) begin
      // data normally wins; fetch gets one turn right after a data grant
      if (if_req && (prev_d_q || !d_req)) begin
        if_gnt = 1'b1;
        rd_idx = if_idx;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  assign rd_word = mem[rd_idx];

  // data access decode
  always_comb begin
    logic illegal;
    dec     = '0;
    illegal = (d_func == 3'b011) || (d_func[2:1] == 2'b11);
    dec.sext = ~d_func[2];
`ifdef MISALIGN_TRAP_EN
    dec.size = d_func[1:0];
    dec.off  = d_addr[1:0];
    dec.bad  = illegal || (d_func[1:0] == 2'b01 && d_addr[0]) ||
               (d_func[1:0] == 2'b10 && d_addr[1:0] != 2'b00);
`else
    dec.bad  = 1'b0;
    dec.size = illegal ? 2'd2 : d_func[1:0];
    case (dec.size)
      2'd0:    dec.off = d_addr[1:0];
      2'd1:    dec.off = {d_addr[1], 1'b0};
      default: dec.off = 2'b00;
    endcase
`endif
  end

  // load formatting and store lane placement
  always_comb begin
    shifted = rd_word >> {dec.off, 3'b000};
    case (dec.size)
      2'd0:    ld_data = {{24{dec.sext & shifted[7]}}, shifted[7:0]};
      2'd1:    ld_data = {{16{dec.sext & shifted[15]}}, shifted[15:0]};
      default: ld_data = rd_word;
    endcase
    case (dec.size)
      2'd0:    mem_be = 4'b0001 << dec.off;
      2'd1:    mem_be = 4'b0011 << dec.off;
      default: mem_be = 4'b1111;
    endcase
    mem_wdata = d_wdata << {dec.off, 3'b000};
  end

  // next state / responses
  always_comb begin
    state_d     = state_q;
    prev_d_d    = 1'b0;
    hold_d      = hold_q;
    hi_idx_d    = hi_idx_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    d_err_d     = 1'b0;
    mem_we      = 1'b0;
    if (state_q == FETCH_HI) begin
      if_rvalid_d = 1'b1;
      if_rdata_d  = {rd_word[15:0], hold_q};
      state_d     = IDLE;
    end
    if (if_gnt) begin
      if (if_addr[1]) begin
        hold_d   = rd_word[31:16];
        hi_idx_d = if_idx + IDX_ONE;  // wraps at the top of the array
        state_d  = FETCH_HI;
      end else begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = rd_word;
      end
    end
    if (d_gnt) begin
      prev_d_d   = 1'b1;
      d_rvalid_d = 1'b1;
      d_rdata_d  = 32'h0;
      if (dec.bad)   d_err_d   = 1'b1;
      else if (d_we) mem_we    = 1'b1;
      else           d_rdata_d = ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      prev_d_q    <= 1'b0;
      hold_q      <= '0;
      hi_idx_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_d_q    <= prev_d_d;
      hold_q      <= hold_d;
      hi_idx_q    <= hi_idx_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  // storage array, not reset; byte-enabled write at the accepting edge
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_be[l]) mem[d_idx][l*8 +: 8] <= mem_wdata[l*8 +: 8];
      end
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
endmodule

// File: tb/tb_unified_mem_responder.sv
module tb_unified_mem_responder;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [2:0]  d_func = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;

  int total = 0;
  int bad = 0;

  logic [31:0] mem_m [1024];

  always #5 clk = ~clk;

  unified_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_func(d_func), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: RISC-V access rules on a word array.
  function automatic void mdl(input bit we, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] wd, output logic [31:0] r, output bit e);
    int idx, sz, off;
    bit mis;
    logic [31:0] v, m;
    idx = int'((a >> 2) & 32'h3FF);
    sz  = (f == 0 || f == 4) ? 1 : (f == 1 || f == 5) ? 2 : 4;
    mis = (f == 3 || f == 6 || f == 7) || (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 0);
    r = 32'h0;
    e = 1'b0;
    if (mis && TRAP) begin
      e = 1'b1;
      return;
    end
    off = (sz == 1) ? int'(a[1:0]) : (sz == 2) ? (a[1] ? 2 : 0) : 0;
    if (we) begin
      for (int i = 0; i < sz; i++) mem_m[idx][8*(off+i) +: 8] = wd[8*i +: 8];
    end else begin
      v = mem_m[idx] >> (8 * off);
      if (sz < 4) begin
        m = (32'd1 << (8 * sz)) - 32'd1;
        v = v & m;
        if (!f[2] && v[8*sz-1]) v = v | ~m;
      end
      r = v;
    end
  endfunction

  function automatic logic [31:0] fexp(input logic [31:0] a);
    int idx;
    idx = int'((a >> 2) & 32'h3FF);
    if (a[1]) return {mem_m[(idx + 1) % 1024][15:0], mem_m[idx][31:16]};
    return mem_m[idx];
  endfunction

  task automatic dop(input bit we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] er;
    bit ee;
    int n;
    mdl(we, f, a, wd, er, ee);
    @(negedge clk);
    d_we = we; d_func = f; d_addr = a; d_wdata = wd; d_req = 1'b1;
    #1;
    n = 0;
    while (d_gnt !== 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
    chk("d_gnt", {31'b0, d_gnt}, 32'd1);
    @(posedge clk); #1;
    d_req = 1'b0;
    chk("d_rvalid", {31'b0, d_rvalid}, 32'd1);
    chk($sformatf("d_rdata we=%0d f=%0d a=%h", we, f, a), d_rdata, er);
    chk("d_err", {31'b0, d_err}, {31'b0, ee});
  endtask

  task automatic fetch(input logic [31:0] a);
    logic [31:0] ex;
    int n;
    ex = fexp(a);
    @(negedge clk);
    if_addr = a; if_req = 1'b1;
    #1;
    n = 0;
    while (if_gnt !== 1'b1 && n < 8) begin @(negedge clk); #1; n++; end
    chk("if_gnt", {31'b0, if_gnt}, 32'd1);
    @(posedge clk); #1;
    if (a[1]) begin
      chk("split gap rvalid", {31'b0, if_rvalid}, 32'd0);
      chk("split gap if_gnt", {31'b0, if_gnt}, 32'd0);
      chk("split gap d_gnt", {31'b0, d_gnt}, 32'd0);
      if_req = 1'b0;
      @(posedge clk); #1;
    end
    if_req = 1'b0;
    chk("if_rvalid", {31'b0, if_rvalid}, 32'd1);
    chk($sformatf("if_rdata a=%h", a), if_rdata, ex);
  endtask

  initial begin
    logic [31:0] er, a;
    bit ee;
    // ---- reset with both requests pending
    d_we = 1'b1; d_func = 3'b010; d_addr = 32'h0; d_wdata = 32'h1111_1111;
    if_addr = 32'h0; if_req = 1'b1; d_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst if_gnt", {31'b0, if_gnt}, 0);
    chk("rst d_gnt", {31'b0, d_gnt}, 0);
    chk("rst if_rvalid", {31'b0, if_rvalid}, 0);
    chk("rst d_rvalid", {31'b0, d_rvalid}, 0);
    chk("rst if_rdata", if_rdata, 0);
    chk("rst d_rdata", d_rdata, 0);
    chk("rst d_err", {31'b0, d_err}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel d_gnt", {31'b0, d_gnt}, 1);
    chk("rel if_gnt", {31'b0, if_gnt}, 0);
    mdl(1'b1, 3'b010, 32'h0, 32'h1111_1111, er, ee);
    @(posedge clk); #1;
    d_req = 1'b0;
    chk("rel d_rvalid", {31'b0, d_rvalid}, 1);
    @(negedge clk); #1;
    chk("rel2 if_gnt", {31'b0, if_gnt}, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
    chk("rel2 if_rvalid", {31'b0, if_rvalid}, 1);
    chk("rel2 if_rdata", if_rdata, 32'h1111_1111);

    // ---- aligned and split fetch
    dop(1'b1, 3'b010, 32'h0C, 32'h00A0_0093);
    fetch(32'h0C);
    dop(1'b1, 3'b010, 32'h0C, 32'hAAAA_1111);
    dop(1'b1, 3'b010, 32'h10, 32'h2222_BBBB);
    fetch(32'h0E);
    chk("split value", if_rdata, 32'hBBBB_AAAA);

    // ---- split fetch wrapping past the last word
    dop(1'b1, 3'b010, 32'hFFC, 32'h5555_6666);
    dop(1'b1, 3'b010, 32'h000, 32'h7777_8888);
    fetch(32'hFFE);
    chk("wrap split", if_rdata, 32'h8888_5555);

    // ---- sub-word store/load
    dop(1'b1, 3'b010, 32'h80, 32'h1234_5678);
    dop(1'b1, 3'b000, 32'h81, 32'h0000_00F0);
    dop(1'b0, 3'b000, 32'h81, 32'h0);
    chk("lb value", d_rdata, 32'hFFFF_FFF0);
    dop(1'b0, 3'b100, 32'h81, 32'h0);
    chk("lbu value", d_rdata, 32'h0000_00F0);
    dop(1'b0, 3'b010, 32'h80, 32'h0);
    chk("lw value", d_rdata, 32'h1234_F078);
    // aliasing through ignored upper address bits
    dop(1'b0, 3'b101, 32'hABCD_E082, 32'h0);

    // ---- misaligned store then readback
    dop(1'b1, 3'b010, 32'h82, 32'hDEAD_BEEF);
    chk("misalign err", {31'b0, d_err}, {31'b0, TRAP});
    dop(1'b0, 3'b010, 32'h80, 32'h0);
    chk("misalign after", d_rdata, TRAP ? 32'h1234_F078 : 32'hDEAD_BEEF);

    // ---- contention: both held for 6 cycles
    dop(1'b1, 3'b010, 32'h08, 32'hC0DE_0008);
    dop(1'b1, 3'b010, 32'h04, 32'hF00D_0004);
    repeat (2) @(posedge clk);
    @(negedge clk);
    d_we = 1'b0; d_func = 3'b010; d_addr = 32'h08; d_req = 1'b1;
    if_addr = 32'h04; if_req = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("cont%0d d_gnt", c), {31'b0, d_gnt}, (c % 2 == 0) ? 1 : 0);
      chk($sformatf("cont%0d if_gnt", c), {31'b0, if_gnt}, (c % 2 == 1) ? 1 : 0);
      @(posedge clk); #1;
      if (c % 2 == 0) begin
        chk("cont d_rvalid", {31'b0, d_rvalid}, 1);
        chk("cont d_rdata", d_rdata, 32'hC0DE_0008);
        chk("cont if_rvalid", {31'b0, if_rvalid}, 0);
      end else begin
        chk("cont if_rvalid", {31'b0, if_rvalid}, 1);
        chk("cont if_rdata", if_rdata, 32'hF00D_0004);
        chk("cont d_rvalid", {31'b0, d_rvalid}, 0);
      end
      @(negedge clk);
    end
    d_req = 1'b0; if_req = 1'b0;

    // ---- reset asserted with a response in flight
    dop(1'b1, 3'b010, 32'h04, 32'h1357_9BDF);
    @(negedge clk);
    d_we = 1'b0; d_func = 3'b010; d_addr = 32'h04; d_req = 1'b1;
    @(posedge clk); #1;
    d_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst d_rvalid", {31'b0, d_rvalid}, 0);
    chk("midrst d_rdata", d_rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("postrst d_rvalid", {31'b0, d_rvalid}, 0);
    chk("postrst if_rvalid", {31'b0, if_rvalid}, 0);

    // ---- randomized traffic against the model
    for (int i = 0; i < 16; i++) dop(1'b1, 3'b010, 32'(i * 4), $urandom);
    for (int i = 0; i < 300; i++) begin
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) begin
        a = ($urandom & 32'hFFFF_F000) | 32'(2 * $urandom_range(0, 29));
        fetch(a);
      end else begin
        dop(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
